regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with a write-back scoreboard: the successor to the single-write, dual-read integer register file in the RV32 core. It provides RD_PORTS combinational read ports, two synchronous write ports, optional same-cycle write-to-read bypass, a hard-wired zero register, and per-register busy bits. The issue stage uses the busy bits to stall on pending writes, which lets a dual-writeback pipeline share one register file.

## Interface
- REG_NUM, 32: number of architectural registers.
- ADDR_W, 5: register address width; REG_NUM ≤ 2^ADDR_W.
- DATA_W, 32: register data width.
- RD_PORTS, 2: number of read ports (1..4).
- BYPASS, 1: 1 = a read returns write data being written in the same cycle.
- ZERO_REG, 1: 1 = register 0 reads as 0, ignores writes and is never busy.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_num  in  RD_PORTS*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  RD_PORTS*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- rd_busy  out  RD_PORTS  per read port: the addressed register has a pending write.
- wr0_en, wr0_num, wr0_data  in  1 / ADDR_W / DATA_W  write port 0 (lower priority).
- wr1_en, wr1_num, wr1_data  in  1 / ADDR_W / DATA_W  write port 1 (higher priority).
- iss_en  in  1  marks the register at iss_num as having a pending write.
- iss_num  in  ADDR_W  destination register being issued.
- busy_vec  out  REG_NUM  raw scoreboard bits; bit r corresponds to register r.

## Operation
- Storage: REG_NUM × DATA_W flops and REG_NUM busy flops. Reset clears all of them asynchronously. After reset, every output reads 0.
- Write:
  - On the rising edge, if wrX_en = 1, the register at wrX_num gets wrX_data.
  - If both ports are enabled with the same address, port 1's data is stored.
  - Writes are ignored when the address is ≥ REG_NUM.
  - Writes are ignored when the address is 0 and ZERO_REG = 1.
- Read (combinational):
  - rd_data[k] = registers[rd_num[k]].
  - It returns 0 when the address is ≥ REG_NUM.
  - It returns 0 when the address is 0 and ZERO_REG = 1.
- Bypass (BYPASS = 1):
  - If wr1 is writing the address read on port k this cycle, rd_data[k] = wr1_data.
  - Otherwise, if wr0 is writing that address, rd_data[k] = wr0_data.
  - Otherwise, rd_data[k] is the stored value.
  - Ignored writes (x0, out of range) never bypass.
- Scoreboard, per register r at each edge:
  - set = iss_en & (iss_num == r).
  - clr = (wr0_en & wr0_num == r) | (wr1_en & wr1_num == r).
  - busy[r] next = set | (busy[r] & ~clr); set wins over clr.
  - busy[0] is constantly 0 when ZERO_REG = 1. Out-of-range iss_num is ignored.
- rd_busy[k]:
  - With BYPASS = 1: busy[rd_num[k]] & ~clr(rd_num[k]), because the data is forwarded this cycle.
  - With BYPASS = 0: busy[rd_num[k]].
  - Out-of-range addresses give 0.
- Writing a register that is not busy is legal: data is stored and busy stays 0.
- Multiple iss_en to the same register without an intervening write leave busy at 1. There is no counting; the issue stage must not issue a second producer.

## Timing
- Read latency is 0 cycles, combinational from rd_num and the stored state.
- Write-to-read latency:
  - With BYPASS = 1: same cycle.
  - With BYPASS = 0: the value is visible from the cycle after the write edge.
- iss_en to busy visible on rd_busy/busy_vec: the next cycle.
- Write clear to busy = 0 on busy_vec: the next cycle. On rd_busy it is the same cycle when BYPASS = 1.
- No combinational path from iss_en or iss_num to any output.
- rst_n asserted mid-operation: registers and busy bits clear immediately, without waiting for clk. Writes and issues present at the first edge after rst_n deasserts take effect normally.

## Test plan
- Reset then read: hold rst_n = 0. Expect rd_data = 0 and busy_vec = 0 for all ports and registers. Write 0xDEADBEEF to x5. Assert rst_n = 0 between clock edges. Expect a read of x5 to give 0 immediately.
- Dual write collision: wr0 and wr1 both write x7, with 0x11111111 and 0x22222222. Next cycle, a read of x7 gives 0x22222222. Writes to x0 of 0xFFFFFFFF: a read of x0 gives 0.
- Bypass (BYPASS = 1): wr0 writes 0xA5A5A5A5 to x3 while port 1 reads x3. rd_data[1] = 0xA5A5A5A5 in the same cycle. Repeat with BYPASS = 0: the old value is returned in that cycle and the new value the next cycle.
- Scoreboard: iss x9. Next cycle, busy_vec[9] = 1 and a read of x9 gives rd_busy = 1. A wr1 to x9 that cycle gives rd_busy = 0 in the same cycle (BYPASS = 1), and busy_vec[9] = 0 on the following cycle.
- Set and clear on the same edge: busy[4] = 1, iss x4 and wr0 x4 on the same edge. Expect the data stored, and busy[4] = 1 afterwards.
- Parameter sweep: RD_PORTS = 4, REG_NUM = 16, ADDR_W = 5, DATA_W = 64.
  - Random writes, issues and reads checked against a reference model.
  - Address 20 reads 0 with busy 0, and writes to it are ignored.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two synchronous write ports,
// combinational read ports, optional write-to-read bypass, optional hard-wired
// zero register and a per-register busy scoreboard for the issue stage.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rd_num   [RD_PORTS*ADDR_W]  read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  [RD_PORTS*DATA_W]  read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy  [RD_PORTS]         addressed register has a pending write
//   wr0_*                       write port 0 (lower priority)
//   wr1_*                       write port 1 (higher priority)
//   iss_en, iss_num             mark a destination register as pending
//   busy_vec [REG_NUM]          raw scoreboard bits
module regfile_mp #(
    parameter int unsigned REG_NUM  = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_num,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_busy,
    input  logic                         wr0_en,
    input  logic [ADDR_W-1:0]            wr0_num,
    input  logic [DATA_W-1:0]            wr0_data,
    input  logic                         wr1_en,
    input  logic [ADDR_W-1:0]            wr1_num,
    input  logic [DATA_W-1:0]            wr1_data,
    input  logic                         iss_en,
    input  logic [ADDR_W-1:0]            iss_num,
    output logic [REG_NUM-1:0]           busy_vec
);

    // Address names a real, writable register (in range and not a hard zero).
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < REG_NUM) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [DATA_W-1:0]  regs_q [REG_NUM];
    logic [DATA_W-1:0]  regs_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    logic wr0_ok;
    logic wr1_ok;
    logic iss_ok;

    assign wr0_ok = wr0_en && addr_ok(wr0_num);
    assign wr1_ok = wr1_en && addr_ok(wr1_num);
    assign iss_ok = iss_en && addr_ok(iss_num);

    // Next state: port 1 applied after port 0 so it wins a collision; the
    // issue set is applied last so it wins over a same-edge write clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned r = 0; r < REG_NUM; r++) begin
            if (wr0_ok && (32'(wr0_num) == r)) begin
                regs_d[r] = wr0_data;
                busy_d[r] = 1'b0;
            end
            if (wr1_ok && (32'(wr1_num) == r)) begin
                regs_d[r] = wr1_data;
                busy_d[r] = 1'b0;
            end
            if (iss_ok && (32'(iss_num) == r)) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // Read ports: stored value, optionally overridden by a same-cycle write,
    // which also means the pending result is being delivered right now.
    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr = rd_num[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = '0;
            busy = 1'b0;
            if (addr_ok(addr)) begin
                for (int unsigned r = 0; r < REG_NUM; r++) begin
                    if (32'(addr) == r) begin
                        data = regs_q[r];
                        busy = busy_q[r];
                    end
                end
            end
            if (BYPASS != 0) begin
                if (wr0_ok && (wr0_num == addr)) begin
                    data = wr0_data;
                    busy = 1'b0;
                end
                if (wr1_ok && (wr1_num == addr)) begin
                    data = wr1_data;
                    busy = 1'b0;
                end
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_busy[k]                  = busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances share one stimulus stream.
//   u_a: 32 x 32-bit, 2 read ports, bypass on, x0 hard-wired.
//   u_b: 16 x 64-bit, 4 read ports, bypass off, x0 an ordinary register.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [19:0] rd_num_b;
    logic        wr0_en;
    logic [4:0]  wr0_num;
    logic [63:0] wr0_data;
    logic        wr1_en;
    logic [4:0]  wr1_num;
    logic [63:0] wr1_data;
    logic        iss_en;
    logic [4:0]  iss_num;

    logic [63:0]  rd_data_a;
    logic [1:0]   rd_busy_a;
    logic [31:0]  busy_vec_a;
    logic [255:0] rd_data_b;
    logic [3:0]   rd_busy_b;
    logic [15:0]  busy_vec_b;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Reference state
    logic [31:0] mem_a  [32];
    bit          busy_a [32];
    logic [63:0] mem_b  [16];
    bit          busy_b [16];

    regfile_mp #(
        .REG_NUM(32), .ADDR_W(5), .DATA_W(32), .RD_PORTS(2), .BYPASS(1), .ZERO_REG(1)
    ) u_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_num   (rd_num_b[9:0]),
        .rd_data  (rd_data_a),
        .rd_busy  (rd_busy_a),
        .wr0_en   (wr0_en),
        .wr0_num  (wr0_num),
        .wr0_data (wr0_data[31:0]),
        .wr1_en   (wr1_en),
        .wr1_num  (wr1_num),
        .wr1_data (wr1_data[31:0]),
        .iss_en   (iss_en),
        .iss_num  (iss_num),
        .busy_vec (busy_vec_a)
    );

    regfile_mp #(
        .REG_NUM(16), .ADDR_W(5), .DATA_W(64), .RD_PORTS(4), .BYPASS(0), .ZERO_REG(0)
    ) u_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_num   (rd_num_b),
        .rd_data  (rd_data_b),
        .rd_busy  (rd_busy_b),
        .wr0_en   (wr0_en),
        .wr0_num  (wr0_num),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_num  (wr1_num),
        .wr1_data (wr1_data),
        .iss_en   (iss_en),
        .iss_num  (iss_num),
        .busy_vec (busy_vec_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            mem_a[r]  = '0;
            busy_a[r] = 1'b0;
        end
        for (int r = 0; r < 16; r++) begin
            mem_b[r]  = '0;
            busy_b[r] = 1'b0;
        end
    endtask

    // One clock edge of architectural behaviour.
    task automatic model_edge();
        // u_a: every 5-bit address is in range, x0 is immutable
        if (wr0_en && wr0_num != 5'd0) mem_a[wr0_num] = wr0_data[31:0];
        if (wr1_en && wr1_num != 5'd0) mem_a[wr1_num] = wr1_data[31:0];
        if (wr0_en) busy_a[wr0_num] = 1'b0;
        if (wr1_en) busy_a[wr1_num] = 1'b0;
        if (iss_en && iss_num != 5'd0) busy_a[iss_num] = 1'b1;
        // u_b: only addresses below 16 exist, x0 is ordinary
        if (wr0_en && wr0_num < 5'd16) begin
            mem_b[wr0_num[3:0]]  = wr0_data;
            busy_b[wr0_num[3:0]] = 1'b0;
        end
        if (wr1_en && wr1_num < 5'd16) begin
            mem_b[wr1_num[3:0]]  = wr1_data;
            busy_b[wr1_num[3:0]] = 1'b0;
        end
        if (iss_en && iss_num < 5'd16) busy_b[iss_num[3:0]] = 1'b1;
    endtask

    always @(negedge rst_n) model_reset();
    always @(posedge clk) if (rst_n) model_edge();

    function automatic logic [31:0] exp_data_a(input logic [4:0] a);
        logic [31:0] e;
        if (a == 5'd0) return 32'h0;
        e = mem_a[a];
        if (wr0_en && wr0_num == a) e = wr0_data[31:0];
        if (wr1_en && wr1_num == a) e = wr1_data[31:0];
        return e;
    endfunction

    function automatic logic exp_busy_a(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if ((wr0_en && wr0_num == a) || (wr1_en && wr1_num == a)) return 1'b0;
        return busy_a[a];
    endfunction

    function automatic logic [63:0] exp_data_b(input logic [4:0] a);
        if (a >= 5'd16) return 64'h0;
        return mem_b[a[3:0]];
    endfunction

    function automatic logic exp_busy_b(input logic [4:0] a);
        if (a >= 5'd16) return 1'b0;
        return busy_b[a[3:0]];
    endfunction

    function automatic logic [31:0] vec_a();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = busy_a[r];
        return v;
    endfunction

    function automatic logic [15:0] vec_b();
        logic [15:0] v;
        for (int r = 0; r < 16; r++) v[r] = busy_b[r];
        return v;
    endfunction

    task automatic compare_all();
        logic [4:0] a;
        for (int k = 0; k < 2; k++) begin
            a = rd_num_b[k*5 +: 5];
            check($sformatf("a_rd_data%0d", k), {32'h0, rd_data_a[k*32 +: 32]}, {32'h0, exp_data_a(a)});
            check($sformatf("a_rd_busy%0d", k), {63'h0, rd_busy_a[k]}, {63'h0, exp_busy_a(a)});
        end
        for (int k = 0; k < 4; k++) begin
            a = rd_num_b[k*5 +: 5];
            check($sformatf("b_rd_data%0d", k), rd_data_b[k*64 +: 64], exp_data_b(a));
            check($sformatf("b_rd_busy%0d", k), {63'h0, rd_busy_b[k]}, {63'h0, exp_busy_b(a)});
        end
        check("a_busy_vec", {32'h0, busy_vec_a}, {32'h0, vec_a()});
        check("b_busy_vec", {48'h0, busy_vec_b}, {48'h0, vec_b()});
    endtask

    // Outputs are sampled mid-cycle; inputs change just after the rising edge.
    always @(negedge clk) if (chk_en) compare_all();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en   = 1'b0;
        wr0_num  = '0;
        wr0_data = '0;
        wr1_en   = 1'b0;
        wr1_num  = '0;
        wr1_data = '0;
        iss_en   = 1'b0;
        iss_num  = '0;
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        rd_num_b[k*5 +: 5] = a;
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_num_b = '0;
        idle();
        model_reset();
        set_rd(0, 5'd5);
        chk_en = 1'b1;

        // Reset state
        tick();
        #1;
        check("rst_a_rd0", {32'h0, rd_data_a[31:0]}, 64'h0);
        check("rst_a_vec", {32'h0, busy_vec_a}, 64'h0);
        check("rst_b_vec", {48'h0, busy_vec_b}, 64'h0);
        tick();
        rst_n = 1'b1;

        // Write x5, then asynchronous reset between edges
        wr0_en = 1'b1; wr0_num = 5'd5; wr0_data = 64'hCAFEF00D_DEADBEEF;
        tick();
        idle();
        #1;
        check("wr_a_x5", {32'h0, rd_data_a[31:0]}, 64'h0000_0000_DEADBEEF);
        check("wr_b_x5", rd_data_b[63:0], 64'hCAFEF00D_DEADBEEF);
        rst_n = 1'b0;
        #1;
        check("async_rst_a_x5", {32'h0, rd_data_a[31:0]}, 64'h0);
        check("async_rst_b_x5", rd_data_b[63:0], 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Dual write collision on x7
        set_rd(0, 5'd7);
        wr0_en = 1'b1; wr0_num = 5'd7; wr0_data = 64'h11111111_11111111;
        wr1_en = 1'b1; wr1_num = 5'd7; wr1_data = 64'h22222222_22222222;
        #1;
        check("coll_bypass_a", {32'h0, rd_data_a[31:0]}, 64'h22222222);
        check("coll_nobyp_b", rd_data_b[63:0], 64'h0);
        tick();
        idle();
        #1;
        check("coll_a_x7", {32'h0, rd_data_a[31:0]}, 64'h22222222);
        check("coll_b_x7", rd_data_b[63:0], 64'h22222222_22222222);

        // Writes to x0
        set_rd(1, 5'd0);
        wr0_en = 1'b1; wr0_num = 5'd0; wr0_data = '1;
        wr1_en = 1'b1; wr1_num = 5'd0; wr1_data = '1;
        #1;
        check("x0_nobypass_a", {32'h0, rd_data_a[63:32]}, 64'h0);
        tick();
        idle();
        #1;
        check("x0_a", {32'h0, rd_data_a[63:32]}, 64'h0);
        check("x0_plain_b", rd_data_b[127:64], 64'hFFFFFFFF_FFFFFFFF);

        // Bypass versus no bypass on x3
        wr0_en = 1'b1; wr0_num = 5'd3; wr0_data = 64'h0000_0000_12345678;
        tick();
        idle();
        set_rd(1, 5'd3);
        wr0_en = 1'b1; wr0_num = 5'd3; wr0_data = 64'hA5A5A5A5_A5A5A5A5;
        #1;
        check("byp_a_same", {32'h0, rd_data_a[63:32]}, 64'hA5A5A5A5);
        check("nobyp_b_old", rd_data_b[127:64], 64'h0000_0000_12345678);
        tick();
        idle();
        #1;
        check("nobyp_b_new", rd_data_b[127:64], 64'hA5A5A5A5_A5A5A5A5);

        // Scoreboard on x9
        iss_en = 1'b1; iss_num = 5'd9;
        tick();
        idle();
        set_rd(0, 5'd9);
        #1;
        check("sb_a_vec9", {63'h0, busy_vec_a[9]}, 64'h1);
        check("sb_a_rdbusy", {63'h0, rd_busy_a[0]}, 64'h1);
        check("sb_b_rdbusy", {63'h0, rd_busy_b[0]}, 64'h1);
        wr1_en = 1'b1; wr1_num = 5'd9; wr1_data = 64'h99;
        #1;
        check("sb_a_fwd_clr", {63'h0, rd_busy_a[0]}, 64'h0);
        check("sb_b_still", {63'h0, rd_busy_b[0]}, 64'h1);
        check("sb_a_vec_still", {63'h0, busy_vec_a[9]}, 64'h1);
        tick();
        idle();
        #1;
        check("sb_a_vec_clr", {63'h0, busy_vec_a[9]}, 64'h0);
        check("sb_b_vec_clr", {63'h0, busy_vec_b[9]}, 64'h0);

        // Set and clear of x4 on the same edge
        iss_en = 1'b1; iss_num = 5'd4;
        tick();
        iss_en = 1'b1; iss_num = 5'd4;
        wr0_en = 1'b1; wr0_num = 5'd4; wr0_data = 64'h44;
        tick();
        idle();
        set_rd(0, 5'd4);
        #1;
        check("setclr_a_data", {32'h0, rd_data_a[31:0]}, 64'h44);
        check("setclr_a_busy", {63'h0, busy_vec_a[4]}, 64'h1);
        check("setclr_b_busy", {63'h0, busy_vec_b[4]}, 64'h1);

        // Issue to x0 and traffic to address 20
        iss_en = 1'b1; iss_num = 5'd0;
        tick();
        idle();
        #1;
        check("iss_x0_a", {63'h0, busy_vec_a[0]}, 64'h0);
        check("iss_x0_b", {63'h0, busy_vec_b[0]}, 64'h1);
        iss_en = 1'b1; iss_num = 5'd20;
        wr0_en = 1'b1; wr0_num = 5'd20; wr0_data = 64'h20202020_20202020;
        tick();
        idle();
        set_rd(0, 5'd20);
        set_rd(2, 5'd20);
        #1;
        check("x20_a_data", {32'h0, rd_data_a[31:0]}, 64'h20202020);
        check("x20_b_data", rd_data_b[191:128], 64'h0);
        check("x20_b_busy", {63'h0, rd_busy_b[2]}, 64'h0);
        check("x20_b_vec", {48'h0, busy_vec_b}, {48'h0, 16'h0011});

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            wr0_en   = 1'($urandom_range(0, 1));
            wr0_num  = 5'($urandom_range(0, 23));
            wr0_data = {$urandom, $urandom};
            wr1_en   = 1'($urandom_range(0, 1));
            wr1_num  = 5'($urandom_range(0, 23));
            wr1_data = {$urandom, $urandom};
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_num  = 5'($urandom_range(0, 23));
            rd_num_b = 20'($urandom);
            tick();
        end
        idle();
        repeat (2) tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
